data_mem_responder: RTL and testbench

Word-organised data memory that answers load/store requests from the CPU core's memory stage over a valid/ready request channel and a valid/ready response channel. It is the target end of the core's data-memory interface: one outstanding request, fixed configurable latency, byte-strobed writes, and an error flag for misaligned or out-of-range addresses. Contents are not reset, so program data survives a core reset.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/byte_strobe_ram.sv | 27 ++
 rtl/data_mem_responder.sv | 107 ++++++++++
 tb/tb_data_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, request/response records.
package mem_pkg;

  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/byte_strobe_ram.sv
// Word array with per-byte write enables and combinational read; never reset so
// contents survive a core reset.
module byte_strobe_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed latency, byte strobes and an
// error flag for misaligned or out-of-range word addresses.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [31:0] REQ_ADDR,
  input  logic [3:0]  REQ_WSTRB,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising CLK edge where valid && ready are
  // both high; REQ_* and RSP_* are only meaningful while their valid is high.

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q;
  mem_rsp_t         rsp_q;
  logic             accept, commit, err;
  logic [29:0]      word_idx;
  logic [31:0]      ram_rdata;

  // Full 30-bit compare so large addresses never alias onto low words.
  assign word_idx = req_q.addr[31:ADDR_LSB];
  assign err      = (req_q.addr[ADDR_LSB-1:0] != '0) || (word_idx >= 30'(DEPTH_WORDS));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    commit    = 1'b0;
    REQ_READY = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = !RSTN;
        if (REQ_VALID && REQ_READY) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = !RSTN;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q <= '{we: REQ_WE, addr: REQ_ADDR, wstrb: REQ_WSTRB, wdata: REQ_WDATA};
      end
      if (commit) begin
        rsp_q.err   <= err;
        rsp_q.rdata <= (err || req_q.we) ? 32'h0 : ram_rdata;
      end
    end
  end

  byte_strobe_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .CLK  (CLK),
    .we   (commit && req_q.we && !err),
    .wstrb(req_q.wstrb),
    .idx  (word_idx[AW-1:0]),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rsp_q.rdata;
  assign RSP_ERR   = rsp_q.err;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus reset/backpressure sequences.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;

  logic        clk;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .CLK      (clk),
    .RSTN     (rstn),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_WE   (req_we),
    .REQ_ADDR (req_addr),
    .REQ_WSTRB(req_wstrb),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid),
    .RSP_READY(rsp_ready),
    .RSP_RDATA(rsp_rdata),
    .RSP_ERR  (rsp_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: present one request in IDLE and let it be accepted at the next edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wstrb = wstrb;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
    req_wdata = $urandom;
  endtask

  // waits for RSP_VALID, counting negedges since the accepting edge
  task automatic wait_rsp();
    int lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("rsp_latency", 32'(lat), 32'(LATENCY + 1));
  endtask

  task automatic score_rsp(input string name);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_rdata"}, rsp_rdata, e[31:0]);
      check({name, "_err"}, 32'(rsp_err), 32'(e[32]));
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_hs", 32'(dbg_state), 32'(IDLE));
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    rsp_ready = 1'b1;
    issue(v.we, v.addr, v.wstrb, v.wdata);
    wait_rsp();
    score_rsp(name);
    finish_rsp();
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] held_rdata;
    logic        held_err;

    rstn      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wstrb = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // we  addr          strb   wdata         exp_rdata     err
    add(1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        0);
    add(0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF, 0);
    add(1, 32'h0000_0010, 4'h5, 32'h11223344, 32'h0,        0);
    add(0, 32'h0000_0010, 4'h0, 32'h0,        32'hDE22BE44, 0);
    add(0, 32'h0000_0013, 4'h0, 32'h0,        32'h0,        1);
    add(1, 32'h0000_0000, 4'hF, 32'h55AA55AA, 32'h0,        0);
    add(1, 32'h0000_0400, 4'hF, 32'hFFFFFFFF, 32'h0,        1);
    add(0, 32'h0000_0000, 4'h0, 32'h0,        32'h55AA55AA, 0);
    add(1, 32'h4000_0000, 4'hF, 32'h12345678, 32'h0,        1);
    add(0, 32'h0000_0000, 4'h0, 32'h0,        32'h55AA55AA, 0);
    add(1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'h0,        0);
    add(0, 32'h0000_0010, 4'h0, 32'h0,        32'hDE22BE44, 0);
    add(1, 32'h0000_03FC, 4'hF, 32'hA5A5A5A5, 32'h0,        0);
    add(0, 32'h0000_03FC, 4'h0, 32'h0,        32'hA5A5A5A5, 0);
    add(1, 32'h0000_0002, 4'hF, 32'h99999999, 32'h0,        1);
    add(0, 32'h0000_0000, 4'h0, 32'h0,        32'h55AA55AA, 0);
    add(1, 32'h0000_0020, 4'hF, 32'h01020304, 32'h0,        0);
    add(1, 32'h0000_0020, 4'hA, 32'hAABBCCDD, 32'h0,        0);
    add(0, 32'h0000_0020, 4'h0, 32'h0,        32'hAA02CC04, 0);

    // reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rstn = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // backpressure: stall 5 cycles in RESP while a new request is offered
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 4'h0, 32'h0);
    wait_rsp();
    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    check("bp_rdata", held_rdata, 32'hDE22BE44);
    check("bp_err", 32'(held_err), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0010;
    req_wstrb = 4'hF;
    req_wdata = 32'h0BAD0BAD;
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, held_rdata);
      check("bp_hold_err", 32'(rsp_err), 32'(held_err));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    check("bp_req_ready_idle", 32'(req_ready), 32'd1);
    run_vec('{we: 0, addr: 32'h10, wstrb: 4'h0, wdata: 32'h0, exp_rdata: 32'hDE22BE44, exp_err: 0},
            "bp_no_store");

    // reset while a store waits: store must be dropped
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("wait_state", 32'(dbg_state), 32'(WAIT));
    rstn = 1'b1;
    @(negedge clk);
    check("wait_rst_req_ready", 32'(req_ready), 32'd0);
    check("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("wait_rst_state", 32'(dbg_state), 32'(IDLE));
    run_vec('{we: 0, addr: 32'h20, wstrb: 4'h0, wdata: 32'h0, exp_rdata: 32'hAA02CC04, exp_err: 0},
            "wait_rst_old");

    // reset while in RESP (coinciding with a handshake): store stays committed
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D);
    wait_rsp();
    rstn      = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("resp_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("resp_rst_rdata", rsp_rdata, 32'h0);
    rstn = 1'b0;
    @(negedge clk);
    check("resp_rst_req_ready", 32'(req_ready), 32'd1);
    run_vec('{we: 0, addr: 32'h20, wstrb: 4'h0, wdata: 32'h0, exp_rdata: 32'hCAFEF00D, exp_err: 0},
            "resp_rst_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
